imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
- Serial program loader; the write side of the 64-word instruction memory that the fetch stage reads.
- Receives UART 8N1 bytes from a host and assembles them big-endian into 32-bit instruction words.
- Emits one write strobe per word toward the instruction RAM write port.
- Holds the CPU in reset while loading is enabled, so a program can be replaced and then single-stepped from PC 0.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 8.
- ADDR_W, 6, instruction RAM word-address width (64 words).

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous active-high reset
- rx  in  1  UART serial input, idle high, asynchronous to clk
- load_en  in  1  load-mode switch; high = accept program bytes
- we  out  1  one-cycle instruction RAM write strobe
- waddr  out  ADDR_W  word address for the write
- wdata  out  32  instruction word for the write
- cpu_rst  out  1  reset to CPU/fetch stage
- busy  out  1  receiver is mid-frame
- word_cnt  out  ADDR_W+1  words written since load_en rose, saturating at 2^ADDR_W
- frame_err  out  1  sticky stop-bit error flag

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - we=0, waddr=0, wdata=0.
  - cpu_rst=1, busy=0, word_cnt=0, frame_err=0.
  - FSM=IDLE, byte_idx=0, rx synchronizer flops=1.
- rx synchronization: passes through 2 flops before any use; all references to rx below mean the synced value.
- load_en: registered once.
  - Rising edge (registered value 0->1) clears waddr, byte_idx, word_cnt and frame_err.
  - cpu_rst is a register that follows (rst | load_en_reg).
- Receiver FSM, with bit-timer cnt and bit index:
  - IDLE: rx==0 -> START, cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1, re-sample rx. If 0 -> DATA, cnt=0, bit=0. If 1 -> IDLE (glitch rejected, no error).
  - DATA: at each cnt==CLKS_PER_BIT-1, shift rx into the shift register LSB-first and reset cnt. After bit 7 -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx.
    - 1 -> byte valid, go to IDLE.
    - 0 -> set frame_err, drop the byte, go to WAIT_HI.
  - WAIT_HI: stay until rx==1, then IDLE.
- busy=1 in every state except IDLE.
- Byte assembly (only when load_en_reg==1 at the stop-sample cycle):
  - byte_idx 0..3 places the byte into wdata[31:24], [23:16], [15:8], [7:0] respectively.
  - The byte landing at byte_idx==3 completes the word.
- Write timing:
  - Stop sample at cycle T completes a word -> we=1 in cycle T+1 only.
  - wdata and waddr are valid in that cycle and held afterwards.
  - In T+2: waddr increments, wrapping 63->0; word_cnt increments, saturating at 64; byte_idx=0.
- Valid bytes received while load_en_reg==0 are discarded, with no write and no state change.
- load_en falling mid-word: byte_idx clears and the partial word is discarded. waddr and word_cnt keep their values.
- A frame error does not disturb byte_idx: the next valid byte fills the same slot.
- load_en rising in the same cycle as a word completion: the clear wins and no write occurs.
- rst mid-frame: everything returns to reset values on the next edge, and any partial word is lost.

Test Plan (CLKS_PER_BIT=16):
- Reset, then load_en=1 and send bytes 00 22 08 20 -> one we pulse with waddr=0, wdata=0x00220820. Then word_cnt=1, cpu_rst=1, frame_err=0.
- Send 8 words, then drop load_en -> 8 we pulses at waddr 0..7, word_cnt=8. cpu_rst falls one cycle after the load_en_reg fall.
- Send 65 words -> the 65th write lands at waddr=0 (wrap), word_cnt stays 64.
- rx low pulse of 5 cycles with load_en=1 -> no byte, busy returns to 0, frame_err=0.
- Send a byte with stop bit=0, then 00 22 08 20 -> frame_err=1 (sticky), one write of 0x00220820. Re-raising load_en clears frame_err.
- Send two bytes, toggle load_en 1->0->1, then send 4 bytes AA BB CC DD -> a single write of 0xAABBCCDD at waddr=0.

Source files
------------

// File: rtl/imem_uart_loader.sv
// Serial program loader: UART 8N1 receiver that packs bytes big-endian into
// 32-bit words and writes them to the instruction RAM while holding the CPU in reset.
module imem_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              load_en,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic [ADDR_W:0]   word_cnt,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W:0]   WORD_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    logic              r_rx_s1;
    logic              r_rx_s2;
    logic              r_load_en;
    logic              r_load_en_q;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [1:0]        r_byte_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_cpu_rst;
    logic              r_busy;
    logic [ADDR_W:0]   r_word_cnt;
    logic              r_frame_err;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_byte_valid;
    logic              w_stop_err;
    logic              w_rx;
    logic              w_le_rise;

    assign w_rx      = r_rx_s2;
    assign w_le_rise = r_load_en & ~r_load_en_q;

    // Two-flop rx synchronizer and registered load_en with edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_load_en   <= 1'b0;
            r_load_en_q <= 1'b0;
            r_cpu_rst   <= 1'b1;
        end else begin
            r_rx_s1     <= rx;
            r_rx_s2     <= r_rx_s1;
            r_load_en   <= load_en;
            r_load_en_q <= r_load_en;
            r_cpu_rst   <= r_load_en;
        end
    end

    // Receiver state register with its bit timer and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Receiver next-state: start bit confirmed at mid-bit, data and stop sampled a full bit later
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_byte_valid = 1'b0;
        w_stop_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    w_state_nxt = w_rx ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_nxt = '0;
                    if (w_rx) begin
                        w_byte_valid = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_stop_err  = 1'b1;
                        w_state_nxt = S_WAIT_HI;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_HI: begin
                if (w_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Word assembly and write port; a load_en rising edge overrides everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_word_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_le_rise) begin
                r_waddr     <= '0;
                r_byte_idx  <= '0;
                r_word_cnt  <= '0;
                r_frame_err <= 1'b0;
            end else begin
                if (w_stop_err) begin
                    r_frame_err <= 1'b1;
                end
                if (r_we) begin
                    r_waddr    <= r_waddr + ADDR_W'(1);
                    r_byte_idx <= '0;
                    if (r_word_cnt != WORD_MAX) begin
                        r_word_cnt <= r_word_cnt + (ADDR_W + 1)'(1);
                    end
                end
                if (!r_load_en) begin
                    r_byte_idx <= '0;
                end else if (w_byte_valid) begin
                    case (r_byte_idx)
                        2'd0:    r_wdata[31:24] <= r_shift;
                        2'd1:    r_wdata[23:16] <= r_shift;
                        2'd2:    r_wdata[15:8]  <= r_shift;
                        default: r_wdata[7:0]   <= r_shift;
                    endcase
                    if (r_byte_idx == 2'd3) begin
                        r_we <= 1'b1;
                    end else begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
            end
        end
    end

    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign busy      = r_busy;
    assign word_cnt  = r_word_cnt;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized bench for imem_uart_loader: a word-level model predicts each RAM write
// into a queue that a negedge monitor drains whenever the loader strobes we.
module tb_imem_uart_loader;

    localparam int unsigned CPB    = 16;
    localparam int unsigned ADDR_W = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx = 1'b1;
    logic              load_en = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_rst;
    logic              busy;
    logic [ADDR_W:0]   word_cnt;
    logic              frame_err;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    // Word-level reference model state
    int          m_addr = 0;
    int          m_cnt  = 0;
    int          m_idx  = 0;
    logic [31:0] m_word = '0;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .load_en   (load_en),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .word_cnt  (word_cnt),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        wr_t w;
        if (load_en) begin
            m_word = {m_word[23:0], b};
            m_idx++;
            if (m_idx == 4) begin
                w.addr = ADDR_W'(m_addr);
                w.data = m_word;
                exp_q.push_back(w);
                m_addr = (m_addr + 1) % (1 << ADDR_W);
                if (m_cnt < (1 << ADDR_W)) m_cnt++;
                m_idx = 0;
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Expectation is queued before the frame goes out so it precedes the write strobe
    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b1, int'($urandom_range(1, 4)));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            logic [7:0] b;
            b = w[i*8 +: 8];
            send_byte(b);
        end
    endtask

    task automatic set_load(input logic v);
        if (v && !load_en) begin
            m_addr = 0;
            m_cnt  = 0;
            m_idx  = 0;
        end
        if (!v) m_idx = 0;
        load_en = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!rst && we) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: waddr=%0d wdata=0x%08h, no write expected", waddr, wdata);
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            check("write_addr", 64'(waddr), 64'(e.addr));
                            check("write_data", 64'(wdata), 64'(e.data));
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_we", 64'(we), 64'(0));
        check("rst_waddr", 64'(waddr), 64'(0));
        check("rst_wdata", 64'(wdata), 64'(0));
        check("rst_cpu_rst", 64'(cpu_rst), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_word_cnt", 64'(word_cnt), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        realign();

        // Single known word
        set_load(1'b1);
        send_word(32'h0022_0820);
        settle();
        check("s1_word_cnt", 64'(word_cnt), 64'(m_cnt));
        check("s1_word_cnt_one", 64'(word_cnt), 64'(1));
        check("s1_cpu_rst", 64'(cpu_rst), 64'(1));
        check("s1_frame_err", 64'(frame_err), 64'(0));
        realign();

        // Eight random words, then drop load_en and watch cpu_rst release
        set_load(1'b0);
        set_load(1'b1);
        for (int i = 0; i < 8; i++) send_word($urandom);
        settle();
        check("s2_word_cnt", 64'(word_cnt), 64'(8));
        realign();
        load_en = 1'b0;
        m_idx   = 0;
        @(posedge clk);
        @(negedge clk);
        check("s2_cpu_rst_hold", 64'(cpu_rst), 64'(1));
        @(posedge clk);
        @(negedge clk);
        check("s2_cpu_rst_fall", 64'(cpu_rst), 64'(0));
        realign();
        send_byte(8'($urandom));
        settle();
        check("s2_discard_cnt", 64'(word_cnt), 64'(8));
        check("s2_discard_busy", 64'(busy), 64'(0));
        realign();

        // 65 words: the last write wraps to address 0 and the count saturates
        set_load(1'b1);
        for (int i = 0; i < 65; i++) send_word($urandom);
        settle();
        check("s3_word_cnt_sat", 64'(word_cnt), 64'(m_cnt));
        check("s3_word_cnt_64", 64'(word_cnt), 64'(64));
        check("s3_waddr_wrap", 64'(waddr), 64'(1));
        realign();

        // Short low glitch on rx is rejected
        rx = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("s4_busy_glitch", 64'(busy), 64'(1));
        realign();
        rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("s4_busy_idle", 64'(busy), 64'(0));
        check("s4_frame_err", 64'(frame_err), 64'(0));
        check("s4_word_cnt", 64'(word_cnt), 64'(64));
        realign();

        // Bad stop bit sets the sticky error without disturbing assembly
        set_load(1'b0);
        set_load(1'b1);
        send_frame(8'($urandom), 1'b0, CPB);
        @(negedge clk);
        check("s5_frame_err_set", 64'(frame_err), 64'(1));
        realign();
        send_word(32'h0022_0820);
        settle();
        check("s5_frame_err_sticky", 64'(frame_err), 64'(1));
        check("s5_word_cnt", 64'(word_cnt), 64'(1));
        realign();
        set_load(1'b0);
        @(negedge clk);
        check("s5_err_after_fall", 64'(frame_err), 64'(1));
        realign();
        set_load(1'b1);
        @(negedge clk);
        check("s5_err_cleared", 64'(frame_err), 64'(0));
        realign();

        // Partial word dropped by a load_en toggle
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        set_load(1'b0);
        set_load(1'b1);
        send_word(32'hAABB_CCDD);
        settle();
        check("s6_word_cnt", 64'(word_cnt), 64'(1));
        check("s6_waddr_next", 64'(waddr), 64'(1));
        realign();

        // Reset in the middle of a frame loses the partial word
        send_byte(8'($urandom));
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rx = 1'b1;
        m_addr = 0;
        m_cnt  = 0;
        m_idx  = 0;
        @(negedge clk);
        check("s7_busy", 64'(busy), 64'(0));
        check("s7_cpu_rst", 64'(cpu_rst), 64'(1));
        check("s7_word_cnt", 64'(word_cnt), 64'(0));
        check("s7_waddr", 64'(waddr), 64'(0));
        realign();
        repeat (4) @(posedge clk);
        #1;
        send_word($urandom);
        settle();
        check("s7_word_cnt_after", 64'(word_cnt), 64'(1));

        repeat (10) @(posedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
